// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC serial responder: FSM state encoding,
// idle line level and default frame geometry.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_DONE     = 3'd5
  } adc_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam int   DEF_DATA_W  = 8;
  localparam int   DEF_PRE_LEN = 3;

endpackage

// File: rtl/adc_serial_tx_if.sv
// Sample load handshake between a word producer (master) and the serial responder (slave).
interface adc_serial_tx_if
  import adc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);

endinterface

// File: rtl/adc_edge_sync.sv
// Two-flop synchronizer for an asynchronous control line, with the synchronized
// level and a one-cycle pulse on each falling edge of that level.
module adc_edge_sync
  import adc_pkg::*;
#(
  parameter logic RST_VAL = LINE_IDLE
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/adc_serial_tx.sv
// Converter-side emulation of the joystick ADC serial link: preamble, start bit,
// LSB-first data word and optional even-parity bit (build with ADC_PARITY_EN).
module adc_serial_tx
  import adc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PRE_LEN = DEF_PRE_LEN
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            sclk,
  input  logic            cs_n,
  adc_serial_tx_if.slave  smp,
  output logic            dout,
  output logic            busy,
  output logic            frame_done
);

  localparam int CNT_W = $clog2(DATA_W + PRE_LEN + 2);

  logic w_sclk_lvl, w_sclk_fall, w_sclk_tick;
  logic w_cs_lvl, w_cs_fall;
  logic w_load, w_abort;

  adc_state_t r_state, w_state_next;
  logic [DATA_W-1:0] r_shadow, r_shift, w_shift_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic r_dout, w_dout_next;
  logic r_busy, w_busy_next;
  logic r_done, w_done_next;
  logic r_par, w_par_next;

  adc_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk_in (clk_in), .reset (reset), .i_async (sclk),
    .o_level(w_sclk_lvl), .o_fall (w_sclk_fall)
  );

  adc_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_in (clk_in), .reset (reset), .i_async (cs_n),
    .o_level(w_cs_lvl), .o_fall (w_cs_fall)
  );

  assign w_sclk_tick       = w_sclk_fall & ~w_sclk_lvl;
  assign smp.sample_ready  = (r_state == ST_IDLE);
  assign w_load            = smp.sample_valid & smp.sample_ready;
  // cs_n deasserted mid-frame overrides any sclk edge seen in the same cycle
  assign w_abort           = (r_state != ST_IDLE) & w_cs_lvl;

  always_ff @(posedge clk_in) begin
    if (!reset) r_shadow <= '0;
    else if (w_load) r_shadow <= smp.sample;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_cs_fall) w_state_next = ST_PREAMBLE;
        ST_PREAMBLE: if (w_sclk_tick && r_cnt == CNT_W'(PRE_LEN - 1)) w_state_next = ST_START;
        ST_START:    if (w_sclk_tick) w_state_next = ST_DATA;
        ST_DATA: begin
          if (w_sclk_tick && r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef ADC_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_DONE;
`endif
          end
        end
        ST_PARITY:   if (w_sclk_tick) w_state_next = ST_DONE;
        ST_DONE:     if (w_sclk_tick) w_state_next = ST_IDLE;
        default:     w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dout_next  = r_dout;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_par_next   = r_par;
    if (w_abort) begin
      w_dout_next = LINE_IDLE;
      w_busy_next = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_dout_next = LINE_IDLE;
          w_busy_next = 1'b0;
          if (w_cs_fall) begin
            w_shift_next = r_shadow;
            w_cnt_next   = '0;
            w_busy_next  = 1'b1;
            w_par_next   = ^r_shadow;
          end
        end
        ST_PREAMBLE: if (w_sclk_tick) begin
          w_dout_next = 1'b1;
          w_cnt_next  = r_cnt + 1'b1;
        end
        ST_START: if (w_sclk_tick) begin
          w_dout_next = 1'b0;
          w_cnt_next  = '0;
        end
        ST_DATA: if (w_sclk_tick) begin
          w_dout_next  = r_shift[0];
          w_shift_next = r_shift >> 1;
          w_cnt_next   = r_cnt + 1'b1;
        end
        ST_PARITY: if (w_sclk_tick) w_dout_next = r_par;
        ST_DONE: if (w_sclk_tick) begin
          w_dout_next = LINE_IDLE;
          w_done_next = 1'b1;
          w_busy_next = 1'b0;
        end
        default: w_dout_next = LINE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_dout  <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else begin
      r_dout  <= w_dout_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_par   <= w_par_next;
    end
  end

  assign dout       = r_dout;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_adc_serial_tx.sv
// Directed bench for adc_serial_tx: table of words with hand-computed frame bits,
// plus reset, busy-load, cs_n-held, abort and mid-frame reset sequences.
module tb_adc_serial_tx;

`ifdef ADC_PARITY_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic sclk   = 1'b1;
  logic cs_n   = 1'b1;
  logic dout, busy, frame_done;

  adc_serial_tx_if #(.DATA_W(8)) u_if ();

  adc_serial_tx #(.DATA_W(8), .PRE_LEN(3)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .smp       (u_if),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_bad  = 0;
  int fd_cnt = 0;

  always @(posedge clk_in) if (frame_done) fd_cnt++;

  typedef struct {
    logic [7:0] word;
    logic [7:0] order;  // data bits in transmit order, leftmost first
    logic       par;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic fall_and_check(input logic exp, input string name);
    @(negedge clk_in) sclk = 1'b0;
    repeat (4) @(negedge clk_in);
    check(name, {31'd0, dout}, {31'd0, exp});
    sclk = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic load_word(input logic [7:0] w);
    @(negedge clk_in);
    u_if.sample       = w;
    u_if.sample_valid = 1'b1;
    check($sformatf("ready_before_load_%02h", w), {31'd0, u_if.sample_ready}, 32'd1);
    @(negedge clk_in);
    u_if.sample_valid = 1'b0;
  endtask

  task automatic cs_assert(input string tag);
    @(negedge clk_in) cs_n = 1'b0;
    repeat (4) @(negedge clk_in);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic cs_release();
    @(negedge clk_in) cs_n = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic frame_bits(input logic [7:0] order, input logic par, input string tag);
    logic [NB-1:0] seq;
    int fd0;
    seq[0] = 1'b1; seq[1] = 1'b1; seq[2] = 1'b1; seq[3] = 1'b0;
    for (int k = 0; k < 8; k++) seq[4+k] = order[7-k];
    if (NB == 14) seq[12] = par;
    seq[NB-1] = 1'b1;
    fd0 = fd_cnt;
    for (int i = 0; i < NB; i++) begin
      fall_and_check(seq[i], $sformatf("%s_bit%0d", tag, i));
    end
    check({tag, "_frame_done_count"}, fd_cnt - fd0, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int fd0;
    vecs[0] = '{8'hAA, 8'b01010101, 1'b0};
    vecs[1] = '{8'h55, 8'b10101010, 1'b0};
    vecs[2] = '{8'h01, 8'b10000000, 1'b1};
    vecs[3] = '{8'h80, 8'b00000001, 1'b1};
    vecs[4] = '{8'hFF, 8'b11111111, 1'b0};
    vecs[5] = '{8'h5A, 8'b01011010, 1'b0};
    vecs[6] = '{8'h07, 8'b11100000, 1'b1};
    vecs[7] = '{8'h03, 8'b11000000, 1'b0};

    u_if.sample       = 8'h00;
    u_if.sample_valid = 1'b0;

    // reset held with sclk toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in) sclk = ~sclk;
    end
    @(negedge clk_in) sclk = 1'b1;
    check("reset_dout", {31'd0, dout}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, u_if.sample_ready}, 32'd1);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);

    // nothing loaded yet: shadow of zero goes out
    cs_assert("noload");
    frame_bits(8'b00000000, 1'b0, "noload");
    cs_release();

    for (int v = 0; v < 8; v++) begin
      load_word(vecs[v].word);
      cs_assert($sformatf("vec%02h", vecs[v].word));
      frame_bits(vecs[v].order, vecs[v].par, $sformatf("vec%02h", vecs[v].word));
      cs_release();
    end

    // valid while busy is refused until the frame ends
    load_word(8'hAA);
    cs_assert("busyload");
    @(negedge clk_in);
    u_if.sample       = 8'h3C;
    u_if.sample_valid = 1'b1;
    @(negedge clk_in);
    check("busyload_ready_low", {31'd0, u_if.sample_ready}, 32'd0);
    frame_bits(8'b01010101, 1'b0, "busyload_AA");
    check("busyload_ready_idle", {31'd0, u_if.sample_ready}, 32'd1);
    u_if.sample_valid = 1'b0;

    // cs_n still low after DONE: no new frame
    fd0 = fd_cnt;
    fall_and_check(1'b1, "cs_held_bit0");
    fall_and_check(1'b1, "cs_held_bit1");
    check("cs_held_busy", {31'd0, busy}, 32'd0);
    check("cs_held_no_done", fd_cnt - fd0, 32'd0);
    cs_release();
    cs_assert("word3C");
    frame_bits(8'b00111100, 1'b0, "word3C");
    cs_release();

    // abort after the sixth fall
    load_word(8'hF0);
    cs_assert("abort");
    fd0 = fd_cnt;
    fall_and_check(1'b1, "abort_b0");
    fall_and_check(1'b1, "abort_b1");
    fall_and_check(1'b1, "abort_b2");
    fall_and_check(1'b0, "abort_b3");
    fall_and_check(1'b0, "abort_b4");
    fall_and_check(1'b0, "abort_b5");
    @(negedge clk_in) cs_n = 1'b1;
    repeat (3) @(negedge clk_in);
    check("abort_dout", {31'd0, dout}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk_in);
    check("abort_no_done", fd_cnt - fd0, 32'd0);
    cs_assert("after_abort");
    frame_bits(8'b00001111, 1'b0, "after_abort");
    cs_release();

    // reset in the middle of a frame, with dout low at that moment
    load_word(8'hAA);
    cs_assert("midreset");
    fall_and_check(1'b1, "midreset_b0");
    fall_and_check(1'b1, "midreset_b1");
    fall_and_check(1'b1, "midreset_b2");
    fall_and_check(1'b0, "midreset_b3");
    fall_and_check(1'b0, "midreset_b4");
    @(negedge clk_in);
    reset = 1'b0;
    cs_n  = 1'b1;
    @(negedge clk_in);
    check("midreset_dout", {31'd0, dout}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ready", {31'd0, u_if.sample_ready}, 32'd1);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    cs_assert("post_reset");
    frame_bits(8'b00000000, 1'b0, "post_reset_zero");
    cs_release();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
